pc_branch_unit: RTL and testbench
=================================

# pc_branch_unit

Program-counter and branch-resolution stage that consumes the registered N, Z, V condition flags from the EX-stage flag register. It holds the architectural PC, evaluates the 3-bit branch condition against the flags, computes branch/jump targets, and latches halt. It drives the instruction-memory address and supplies the link address for JAL to the register-file write path.

## Interface

Parameters:
- `RESET_PC`, 16'h0000: PC value loaded on reset.

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `N`, input, 1: registered negative flag.
- `Z`, input, 1: registered zero flag.
- `V`, input, 1: registered overflow flag.
- `br`, input, 1: current instruction is a conditional branch.
- `ccc`, input, 3: branch condition code.
- `br_off`, input, 9: signed branch offset, in words.
- `jal`, input, 1: jump-and-link.
- `jal_off`, input, 12: signed JAL offset, in words.
- `jr`, input, 1: jump-register.
- `jr_tgt`, input, 16: register value used as the JR target.
- `hlt`, input, 1: halt instruction decoded.
- `stall`, input, 1: hold PC this cycle.
- `pc`, output, 16: current PC, registered.
- `pc_plus1`, output, 16: combinational `pc + 1`, modulo 2^16.
- `link_addr`, output, 16: equals `pc_plus1`. Written to R15 on JAL by the register file.
- `taken`, output, 1: combinational. High when `br` is high and the condition is true, or when `jal` or `jr` is high. Forced low while halted.
- `halted`, output, 1: registered halt status.
- `instr_cnt`, output, 16: registered count of retired instructions.

## Operation

Condition decode, evaluated on the flag values present this cycle:
- 000: NEQ, taken when !Z
- 001: EQ, taken when Z
- 010: GT, taken when !Z && !N
- 011: LT, taken when N
- 100: GTE, taken when !N
- 101: LTE, taken when N || Z
- 110: OVFL, taken when V
- 111: UNCOND, always taken

Target computation (all arithmetic is 16-bit, wraps modulo 2^16, no overflow detection):
- Branch target = `pc_plus1 + sext(br_off)`
- JAL target = `pc_plus1 + sext(jal_off)`
- JR target = `jr_tgt`

FSM states:
- RUN: the PC advances each cycle.
- HALTED: PC and `instr_cnt` are frozen. The only exit is reset.
- Transition: RUN to HALTED on any edge where `hlt` is high and `stall` is low.

Next-PC priority, highest first:
1. Reset: PC loads `RESET_PC`.
2. HALTED: PC holds.
3. `hlt` in RUN: PC holds, state moves to HALTED. `hlt` beats any simultaneous jump or branch.
4. `stall`: PC holds, no state change, `hlt` is ignored this cycle.
5. `jr`: PC loads the JR target.
6. `jal`: PC loads the JAL target.
7. `br` with condition true: PC loads the branch target.
8. Otherwise: PC loads `pc_plus1`.

Retired-instruction counter:
- Increments by 1 on every edge where the state is RUN and `stall` is low, including the edge that retires `hlt`.
- Wraps from 16'hFFFF to 0.

Illegal input combinations:
- More than one of `jr`, `jal`, `br` high at once is a decoder error. The priority order above still determines the result.

## Timing

- Reset values: `pc` = `RESET_PC`, `halted` = 0, `instr_cnt` = 0, state = RUN. Reset takes effect immediately on `rst_n` falling, with no clock required.
- Reset asserted while HALTED returns the block to RUN with `pc` = `RESET_PC`.
- Latency: the next PC appears on `pc` one cycle after the decode inputs are presented.
- `taken`, `pc_plus1` and `link_addr` are combinational from the current-cycle `pc` and inputs.
- Flags are consumed exactly as registered, so a branch sees the flags set by the previous flag-writing instruction. There is no bypass.
- `halted` rises on the same edge at which the PC freezes.
- Wrap-around:
  - `pc` = 16'hFFFF with no jump gives next `pc` = 16'h0000.
  - Backward offsets from 0 wrap. Example: `pc` = 0, `br_off` = -2 gives target 16'hFFFF.

## Test plan

- Reset, then 4 cycles with no control inputs: `pc` steps 0 to 1 to 2 to 3 to 4, `instr_cnt` = 4, `halted` = 0.
- Condition sweep, `pc` = 16'h0010, `br` = 1, `br_off` = 9'h005. For each `ccc` and each N/Z/V combination: `taken` matches the decode table, and next `pc` is 16'h0016 when taken, 16'h0011 otherwise.
- JAL at `pc` = 16'h0020 with `jal_off` = 12'hFF0 (-16): `link_addr` = 16'h0021, next `pc` = 16'h0011.
- JR with `jr_tgt` = 16'hBEEF while `br` = 1: next `pc` = 16'hBEEF, because JR has priority.
- Wrap cases:
  - `pc` = 16'hFFFF, no control: next `pc` = 16'h0000.
  - `pc` = 0, `br` = 1, `ccc` = 111, `br_off` = 9'h1FE (-2): next `pc` = 16'hFFFF.
- Halt and stall:
  - `stall` = 1 together with `hlt` = 1: PC holds and `halted` stays 0.
  - Next cycle, `hlt` = 1 with `jal` = 1: PC holds, `halted` = 1, `instr_cnt` increments once.
  - Then `pc` and `instr_cnt` stay frozen for 10 cycles.
  - Asynchronous `rst_n` pulse mid-cycle: `pc` = 0, `halted` = 0 immediately.

Source files
------------

// File: rtl/pc_branch_unit.sv
// Program counter and branch resolution: evaluates the branch condition on the registered
// N/Z/V flags, selects the next PC, counts retired instructions and latches halt.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  S_RUN    | PC advances every unstalled cycle, instr_cnt counts retires
//  S_HALTED | PC and instr_cnt frozen; left only through rst_n
module pc_branch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        N,
   input  logic        Z,
   input  logic        V,
   input  logic        br,
   input  logic [2:0]  ccc,
   input  logic [8:0]  br_off,
   input  logic        jal,
   input  logic [11:0] jal_off,
   input  logic        jr,
   input  logic [15:0] jr_tgt,
   input  logic        hlt,
   input  logic        stall,
   output logic [15:0] pc,
   output logic [15:0] pc_plus1,
   output logic [15:0] link_addr,
   output logic        taken,
   output logic        halted,
   output logic [15:0] instr_cnt
);

   typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [15:0] pc_nxt, cnt_nxt;
   logic [15:0] br_tgt, jal_tgt;
   logic        cond_true;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_RUN;
         pc        <= RESET_PC;
         instr_cnt <= 16'h0000;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         instr_cnt <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (state == S_RUN && hlt && !stall)
         state_nxt = S_HALTED;
   end

   always_comb begin
      cond_true = 1'b0;
      case (ccc)
         3'b000:  cond_true = !Z;
         3'b001:  cond_true = Z;
         3'b010:  cond_true = !Z && !N;
         3'b011:  cond_true = N;
         3'b100:  cond_true = !N;
         3'b101:  cond_true = N || Z;
         3'b110:  cond_true = V;
         default: cond_true = 1'b1;
      endcase
   end

   assign pc_plus1  = pc + 16'd1;
   assign link_addr = pc_plus1;
   assign br_tgt    = pc_plus1 + {{7{br_off[8]}}, br_off};
   assign jal_tgt   = pc_plus1 + {{4{jal_off[11]}}, jal_off};

   always_comb begin
      pc_nxt  = pc;
      cnt_nxt = instr_cnt;
      halted  = (state == S_HALTED);
      taken   = (state == S_RUN) && ((br && cond_true) || jal || jr);
      if (state == S_RUN && !stall) begin
         // the hlt edge retires hlt itself, so the count still advances
         cnt_nxt = instr_cnt + 16'd1;
         if (hlt)
            pc_nxt = pc;
         else if (jr)
            pc_nxt = jr_tgt;
         else if (jal)
            pc_nxt = jal_tgt;
         else if (br && cond_true)
            pc_nxt = br_tgt;
         else
            pc_nxt = pc_plus1;
      end
   end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: vector table for next-PC/taken selection plus
// hand-written sequences for reset, halt/stall and asynchronous reset.
module tb_pc_branch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        N, Z, V, br, jal, jr, hlt, stall;
   logic [2:0]  ccc;
   logic [8:0]  br_off;
   logic [11:0] jal_off;
   logic [15:0] jr_tgt;
   logic [15:0] pc, pc_plus1, link_addr, instr_cnt;
   logic        taken, halted;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string       name;
      logic [15:0] start_pc;
      logic [2:0]  nzv;
      logic        br;
      logic [2:0]  ccc;
      logic [8:0]  br_off;
      logic        jal;
      logic [11:0] jal_off;
      logic        jr;
      logic [15:0] jr_tgt;
      logic        exp_taken;
      logic [15:0] exp_link;
      logic [15:0] exp_pc;
   } vec_t;

   vec_t vecs[$];

   pc_branch_unit #(.RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n), .N(N), .Z(Z), .V(V), .br(br), .ccc(ccc),
      .br_off(br_off), .jal(jal), .jal_off(jal_off), .jr(jr), .jr_tgt(jr_tgt),
      .hlt(hlt), .stall(stall), .pc(pc), .pc_plus1(pc_plus1), .link_addr(link_addr),
      .taken(taken), .halted(halted), .instr_cnt(instr_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      N = 0; Z = 0; V = 0; br = 0; ccc = 3'd0; br_off = 9'd0;
      jal = 0; jal_off = 12'd0; jr = 0; jr_tgt = 16'd0; hlt = 0; stall = 0;
   endtask

   function automatic logic cond_model(input logic [2:0] c, input logic n, input logic z,
                                       input logic v);
      case (c)
         3'd0: return !z;
         3'd1: return z;
         3'd2: return !z && !n;
         3'd3: return n;
         3'd4: return !n;
         3'd5: return n || z;
         3'd6: return v;
         default: return 1'b1;
      endcase
   endfunction

   task automatic add_vec(input string name, input logic [15:0] spc, input logic [2:0] nzv,
                          input logic b, input logic [2:0] c, input logic [8:0] bo,
                          input logic j, input logic [11:0] jo, input logic r,
                          input logic [15:0] rt, input logic et, input logic [15:0] el,
                          input logic [15:0] ep);
      vec_t v;
      v.name = name; v.start_pc = spc; v.nzv = nzv; v.br = b; v.ccc = c; v.br_off = bo;
      v.jal = j; v.jal_off = jo; v.jr = r; v.jr_tgt = rt;
      v.exp_taken = et; v.exp_link = el; v.exp_pc = ep;
      vecs.push_back(v);
   endtask

   initial begin
      logic [15:0] pc_hold, cnt_hold;
      logic        t;

      // condition sweep at pc 0x0010, offset +5
      for (int c = 0; c < 8; c++)
         for (int f = 0; f < 8; f++) begin
            t = cond_model(3'(c), f[2], f[1], f[0]);
            add_vec($sformatf("cond_c%0d_nzv%0d", c, f), 16'h0010, 3'(f), 1'b1, 3'(c),
                    9'h005, 1'b0, 12'h000, 1'b0, 16'h0000, t, 16'h0011,
                    t ? 16'h0016 : 16'h0011);
         end
      add_vec("jal_back",  16'h0020, 3'b000, 1'b0, 3'd0, 9'h000, 1'b1, 12'hFF0, 1'b0,
              16'h0000, 1'b1, 16'h0021, 16'h0011);
      add_vec("jr_over_br", 16'h0030, 3'b000, 1'b1, 3'd7, 9'h005, 1'b0, 12'h000, 1'b1,
              16'hBEEF, 1'b1, 16'h0031, 16'hBEEF);
      add_vec("jal_over_br", 16'h0040, 3'b000, 1'b1, 3'd7, 9'h005, 1'b1, 12'h003, 1'b0,
              16'h0000, 1'b1, 16'h0041, 16'h0044);
      add_vec("jr_over_jal", 16'h0050, 3'b000, 1'b0, 3'd0, 9'h000, 1'b1, 12'h003, 1'b1,
              16'h1234, 1'b1, 16'h0051, 16'h1234);
      add_vec("wrap_ffff", 16'hFFFF, 3'b000, 1'b0, 3'd0, 9'h000, 1'b0, 12'h000, 1'b0,
              16'h0000, 1'b0, 16'h0000, 16'h0000);
      add_vec("wrap_br_neg", 16'h0000, 3'b000, 1'b1, 3'd7, 9'h1FE, 1'b0, 12'h000, 1'b0,
              16'h0000, 1'b1, 16'h0001, 16'hFFFF);
      add_vec("br_fwd_max", 16'h0100, 3'b010, 1'b1, 3'd1, 9'h0FF, 1'b0, 12'h000, 1'b0,
              16'h0000, 1'b1, 16'h0101, 16'h0200);

      // reset and free-running advance
      idle_inputs();
      rst_n = 1'b0;
      #12;
      chk("reset_pc", pc, 16'h0000);
      chk("reset_cnt", instr_cnt, 16'h0000);
      chk("reset_halted", {15'd0, halted}, 16'd0);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("run4_pc", pc, 16'h0004);
      chk("run4_cnt", instr_cnt, 16'h0004);
      chk("run4_halted", {15'd0, halted}, 16'd0);

      foreach (vecs[i]) begin
         idle_inputs();
         jr = 1'b1; jr_tgt = vecs[i].start_pc;
         @(posedge clk); #1;
         idle_inputs();
         {N, Z, V} = vecs[i].nzv;
         br = vecs[i].br; ccc = vecs[i].ccc; br_off = vecs[i].br_off;
         jal = vecs[i].jal; jal_off = vecs[i].jal_off;
         jr = vecs[i].jr; jr_tgt = vecs[i].jr_tgt;
         #1;
         chk({vecs[i].name, "_taken"}, {15'd0, taken}, {15'd0, vecs[i].exp_taken});
         chk({vecs[i].name, "_link"}, link_addr, vecs[i].exp_link);
         @(posedge clk); #1;
         chk({vecs[i].name, "_pc"}, pc, vecs[i].exp_pc);
      end

      // stall masks hlt, then hlt beats jal
      idle_inputs();
      jr = 1'b1; jr_tgt = 16'h0200;
      @(posedge clk); #1;
      idle_inputs();
      cnt_hold = instr_cnt;
      stall = 1'b1; hlt = 1'b1;
      @(posedge clk); #1;
      chk("stall_hlt_pc", pc, 16'h0200);
      chk("stall_hlt_halted", {15'd0, halted}, 16'd0);
      chk("stall_hlt_cnt", instr_cnt, cnt_hold);
      stall = 1'b0; hlt = 1'b1; jal = 1'b1; jal_off = 12'h010;
      #1;
      chk("pre_halt_taken", {15'd0, taken}, 16'd1);
      @(posedge clk); #1;
      chk("halt_pc", pc, 16'h0200);
      chk("halt_halted", {15'd0, halted}, 16'd1);
      chk("halt_cnt", instr_cnt, cnt_hold + 16'd1);
      chk("halted_taken", {15'd0, taken}, 16'd0);
      pc_hold = pc; cnt_hold = instr_cnt;
      for (int k = 0; k < 10; k++) begin
         idle_inputs();
         jr = k[0]; jr_tgt = 16'h4444; br = 1'b1; ccc = 3'd7; hlt = k[1];
         @(posedge clk); #1;
         chk($sformatf("frozen_pc_%0d", k), pc, pc_hold);
         chk($sformatf("frozen_cnt_%0d", k), instr_cnt, cnt_hold);
      end

      // asynchronous reset mid-cycle while halted
      idle_inputs();
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_pc", pc, 16'h0000);
      chk("async_rst_halted", {15'd0, halted}, 16'd0);
      chk("async_rst_cnt", instr_cnt, 16'h0000);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_pc", pc, 16'h0001);
      chk("post_rst_cnt", instr_cnt, 16'h0001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
